// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback controller.
// Data and address widths here must match the reg_wb_ctrl parameters.
package wb_pkg;

    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of secondary writeback requests with per-entry valid bits,
// so queued entries can be killed by destination address. WB_PENDING_EN exposes the entries.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push_i,
    input  wb_req_t                           push_req_i,
    input  logic                              pop_i,
    input  logic                              kill_en_i,
    input  logic [WB_ADDR_W-1:0]              kill_addr_i,
    output wb_req_t                           head_o,
    output logic [$clog2(DEPTH):0]            count_o
`ifdef WB_PENDING_EN
    ,
    output logic [DEPTH-1:0]                  ent_valid_o,
    output logic [DEPTH-1:0][WB_ADDR_W-1:0]   ent_addr_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [DEPTH-1:0][WB_ADDR_W-1:0] addr_q, addr_d;
    logic [WB_DATA_W-1:0]            data_q [DEPTH];
    logic [WB_DATA_W-1:0]            data_d [DEPTH];
    logic [PTR_W-1:0]                rptr_q, rptr_d;
    logic [PTR_W-1:0]                wptr_q, wptr_d;
    logic [CNT_W-1:0]                count_q, count_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;

        // Kill sees only entries stored before this cycle; a same-cycle push stays live.
        if (kill_en_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (addr_q[i] == kill_addr_i)) begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        if (pop_i) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + PTR_W'(1);
        end

        if (push_i) begin
            valid_d[wptr_q] = push_req_i.valid;
            addr_d[wptr_q]  = push_req_i.addr;
            data_d[wptr_q]  = push_req_i.data;
            wptr_d          = wptr_q + PTR_W'(1);
        end

        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            addr_q  <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: it is only consumed behind a valid bit.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    always_comb begin
        head_o.valid = valid_q[rptr_q];
        head_o.addr  = addr_q[rptr_q];
        head_o.data  = data_q[rptr_q];
    end

    assign count_o = count_q;

`ifdef WB_PENDING_EN
    assign ent_valid_o = valid_q;
    assign ent_addr_o  = addr_q;
`endif

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-port arbiter: main pipeline first, then queued secondary writes.
// WB_PENDING_EN adds chk_addr1/2 -> pend_hit1/2 outstanding-write lookups.
module reg_wb_ctrl
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_valid,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              sec_valid,
    output logic              sec_ready,
    input  logic [ADDR_W-1:0] sec_addr,
    input  logic [DATA_W-1:0] sec_data,
    output logic              write_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
`ifdef WB_PENDING_EN
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              pend_hit1,
    output logic              pend_hit2,
`endif
    output logic              idle
);

    localparam int unsigned        CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    logic              write_en_q, write_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              pipe_hit;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    wb_req_t           push_req;
    wb_req_t           head;
    logic [CNT_W-1:0]  count;

`ifdef WB_PENDING_EN
    logic [DEPTH-1:0]                ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0]    ent_addr;
`endif

    assign pipe_hit   = pipe_valid && (pipe_addr != REG_ZERO);
    assign fifo_empty = (count == '0);
    assign sec_ready  = (count < FULL_CNT);
    // r0 requests complete the handshake but are never queued.
    assign fifo_push  = sec_valid && sec_ready && (sec_addr != REG_ZERO);
    assign fifo_pop   = !pipe_hit && !fifo_empty;

    always_comb begin
        push_req.valid = 1'b1;
        push_req.addr  = sec_addr;
        push_req.data  = sec_data;
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_req_i  (push_req),
        .pop_i       (fifo_pop),
        .kill_en_i   (pipe_hit),
        .kill_addr_i (pipe_addr),
        .head_o      (head),
        .count_o     (count)
`ifdef WB_PENDING_EN
        ,
        .ent_valid_o (ent_valid),
        .ent_addr_o  (ent_addr)
`endif
    );

    // A killed head is still popped, but its slot issues no write.
    always_comb begin
        write_en_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (pipe_hit) begin
            write_en_d = 1'b1;
            wr_addr_d  = pipe_addr;
            wr_data_d  = pipe_data;
        end else if (fifo_pop && head.valid) begin
            write_en_d = 1'b1;
            wr_addr_d  = head.addr;
            wr_data_d  = head.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_en_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            write_en_q <= write_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign write_en = write_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign idle     = fifo_empty && !write_en_q;

`ifdef WB_PENDING_EN
    function automatic logic pend_match(
        input logic [ADDR_W-1:0]             chk,
        input logic [DEPTH-1:0]              ev,
        input logic [DEPTH-1:0][ADDR_W-1:0]  ea,
        input logic                          we,
        input logic [ADDR_W-1:0]             wa
    );
        logic hit;
        hit = we && (wa == chk);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ev[i] && (ea[i] == chk)) begin
                hit = 1'b1;
            end
        end
        return hit && (chk != REG_ZERO);
    endfunction

    assign pend_hit1 = pend_match(chk_addr1, ent_valid, ent_addr, write_en_q, wr_addr_q);
    assign pend_hit2 = pend_match(chk_addr2, ent_valid, ent_addr, write_en_q, wr_addr_q);
`endif

endmodule
